// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: shares one lane encoder between OS, CTRL and DATA sources, granting
// whole symbols with strict OS priority and round-robin, burst-limited CTRL/DATA.
`default_nettype none

module tx_lane_scheduler #(
   parameter logic [3:0] OS_DSEL   = 4'd8,
   parameter logic [3:0] CTRL_DSEL = 4'd1,
   parameter logic [3:0] DATA_DSEL = 4'd2,
   parameter logic [3:0] IDLE_DSEL = 4'd0,
   parameter int         MAX_BURST = 4
) (
   input  logic       enc_clk,
   input  logic       rst,
   input  logic [1:0] gen_speed,
   input  logic [2:0] req,
   input  logic [2:0] last,
   output logic [2:0] gnt,
   output logic       byte_rd,
   output logic       enc_enable,
   output logic [3:0] d_sel,
   output logic       sym_done,
   output logic       busy
);
   localparam int            BW        = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SYM  = 2'd2
   } state_t;

   state_t        state;
   logic [1:0]    speed;
   logic [3:0]    bcnt;
   logic [BW-1:0] burst;
   logic          rr_data;   // DATA wins the next CTRL/DATA tie

   logic [3:0]    last_idx;
   logic          sym_end;
   logic [2:0]    pick;
   logic [3:0]    pick_dsel;
   logic          own_done;
   logic          other_req;
   logic [BW-1:0] burst_next;
   logic          keep;
   logic          grant_now;
   logic          stop_now;

   always_comb begin
      case (speed)
         2'd2:    last_idx = 4'd7;
         2'd1:    last_idx = 4'd15;
         default: last_idx = 4'd0;
      endcase
      sym_end = (bcnt == last_idx);

      if (req[0])                pick = 3'b001;
      else if (req[1] && req[2]) pick = rr_data ? 3'b100 : 3'b010;
      else                       pick = {req[2], req[1], 1'b0};
      pick_dsel = pick[0] ? OS_DSEL : (pick[1] ? CTRL_DSEL : DATA_DSEL);

      // A request dropped during the symbol counts as the owner's final symbol.
      own_done   = |(gnt & (last | ~req));
      other_req  = (gnt[1] & req[2]) | (gnt[2] & req[1]);
      burst_next = (burst == BURST_CAP) ? burst : burst + BW'(1);
      keep       = !own_done &&
                   (gnt[0] || (!req[0] && !((burst_next == BURST_CAP) && other_req)));

      grant_now = ((state == ARB) && (req != 3'b000)) ||
                  ((state == SYM) && sym_end && !keep && (pick != 3'b000));
      stop_now  = ((state == ARB) && (req == 3'b000)) ||
                  ((state == SYM) && sym_end && !keep && (pick == 3'b000));
   end

   always_ff @(posedge enc_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         speed      <= 2'd0;
         bcnt       <= 4'd0;
         burst      <= '0;
         rr_data    <= 1'b0;
         gnt        <= 3'b000;
         byte_rd    <= 1'b0;
         enc_enable <= 1'b0;
         d_sel      <= IDLE_DSEL;
         sym_done   <= 1'b0;
         busy       <= 1'b0;
      end else if (grant_now) begin
         state      <= SYM;
         gnt        <= pick;
         d_sel      <= pick_dsel;
         byte_rd    <= 1'b1;
         enc_enable <= 1'b1;
         busy       <= 1'b1;
         bcnt       <= 4'd0;
         burst      <= '0;
         sym_done   <= (last_idx == 4'd0);
         if (pick[1])      rr_data <= 1'b1;
         else if (pick[2]) rr_data <= 1'b0;
      end else if (stop_now) begin
         state      <= IDLE;
         gnt        <= 3'b000;
         byte_rd    <= 1'b0;
         enc_enable <= 1'b0;
         d_sel      <= IDLE_DSEL;
         sym_done   <= 1'b0;
         busy       <= 1'b0;
         bcnt       <= 4'd0;
         burst      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((req != 3'b000) && (gen_speed != 2'd3)) begin
                  state <= ARB;
                  speed <= gen_speed;
                  busy  <= 1'b1;
               end
            end
            SYM: begin
               if (sym_end) begin
                  bcnt     <= 4'd0;
                  burst    <= burst_next;
                  sym_done <= (last_idx == 4'd0);
               end else begin
                  bcnt     <= bcnt + 4'd1;
                  sym_done <= ((bcnt + 4'd1) == last_idx);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

`default_nettype wire
